// File: rtl/bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl
//
// Moves one data word over the shared labcpu data bus. The source can be a
// bus register or an external word, and the destination is a bus register.
// For a register source the controller enables that register onto the bus for
// one cycle and captures the word. It then drives the captured word back to
// all register inputs and strobes the destination's write enable for one cycle.
//
// Ports
//   i_w_clk        clock, all state changes on the rising edge
//   i_w_reset      asynchronous active-high reset
//   i_w_start      transfer request, only looked at while idle
//   i_w_src        source register index (ignored when i_w_src_ext = 1)
//   i_w_dst        destination register index
//   i_w_src_ext    1 = take the source word from i_w_ext_data
//   i_w_ext_data   external source word
//   i_w_bus_in     OR of all bus register outputs
//   o_w_oe         one-hot register output enables (READ only)
//   o_w_we         one-hot register write enables (WRITE only)
//   o_w_bus        write data to every register input (zero outside WRITE)
//   o_w_busy       high while in READ or WRITE
//   o_w_done       one-cycle pulse when a transfer completes
//   o_w_err        one-cycle pulse after a rejected request
//   o_w_xfer_count number of completed transfers, wraps at 256
// -----------------------------------------------------------------------------
module bus_xfer_ctrl #(
    parameter int p_data_width = 16,
    parameter int p_num_regs   = 8,
    parameter int p_idx_width  = 3
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    input  logic                    i_w_start,
    input  logic [p_idx_width-1:0]  i_w_src,
    input  logic [p_idx_width-1:0]  i_w_dst,
    input  logic                    i_w_src_ext,
    input  logic [p_data_width-1:0] i_w_ext_data,
    input  logic [p_data_width-1:0] i_w_bus_in,
    output logic [p_num_regs-1:0]   o_w_oe,
    output logic [p_num_regs-1:0]   o_w_we,
    output logic [p_data_width-1:0] o_w_bus,
    output logic                    o_w_busy,
    output logic                    o_w_done,
    output logic                    o_w_err,
    output logic [7:0]              o_w_xfer_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Register count, widened by one bit so an index can be range-checked
    // even when p_num_regs equals 2**p_idx_width.
    localparam logic [p_idx_width:0] c_num_regs = p_num_regs[p_idx_width:0];

    logic [1:0]              r_state;
    logic [p_idx_width-1:0]  r_src;
    logic [p_idx_width-1:0]  r_dst;
    logic [p_data_width-1:0] r_hold;
    logic                    r_err;
    logic [7:0]              r_count;

    logic w_src_ok;
    logic w_dst_ok;
    logic w_reg_req_ok;
    logic w_ext_req_ok;

    assign w_src_ok     = ({1'b0, i_w_src} < c_num_regs);
    assign w_dst_ok     = ({1'b0, i_w_dst} < c_num_regs);
    assign w_reg_req_ok = !i_w_src_ext && (i_w_src != i_w_dst) && w_src_ok && w_dst_ok;
    assign w_ext_req_ok = i_w_src_ext && w_dst_ok;

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_hold  <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            // The error flag is a pulse. It is raised only by a rejected request.
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_w_start) begin
                        if (w_reg_req_ok) begin
                            r_src   <= i_w_src;
                            r_dst   <= i_w_dst;
                            r_state <= ST_READ;
                        end else if (w_ext_req_ok) begin
                            // The external word skips the bus read phase.
                            r_hold  <= i_w_ext_data;
                            r_dst   <= i_w_dst;
                            r_state <= ST_WRITE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    r_hold  <= i_w_bus_in;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    // Update the count on entry to DONE so that it is already
                    // current while the done pulse is high.
                    r_count <= r_count + 8'd1;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded from registered state and latched indices only.
    // A new request cannot reach them within the same cycle.
    generate
        for (genvar gi = 0; gi < p_num_regs; gi++) begin : g_strobe
            localparam int c_gi = gi;
            localparam logic [p_idx_width-1:0] c_idx = c_gi[p_idx_width-1:0];
            assign o_w_oe[gi] = (r_state == ST_READ)  && (r_src == c_idx);
            assign o_w_we[gi] = (r_state == ST_WRITE) && (r_dst == c_idx);
        end
    endgenerate

    assign o_w_bus        = (r_state == ST_WRITE) ? r_hold : '0;
    assign o_w_busy       = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign o_w_done       = (r_state == ST_DONE);
    assign o_w_err        = r_err;
    assign o_w_xfer_count = r_count;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
module tb_bus_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  src = '0;
    logic [2:0]  dst = '0;
    logic        src_ext = 1'b0;
    logic [15:0] ext_data = '0;
    logic [15:0] bus_in;
    logic [7:0]  oe;
    logic [7:0]  we;
    logic [15:0] bus;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  xfer_count;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int done_base;

    // Behavioural model of the bus registers. Each register latches the bus on
    // the negative clock edge while its write enable is high.
    logic [15:0] regs [8] = '{default: 16'h0000};

    always #5 clk = ~clk;

    bus_xfer_ctrl dut (
        .i_w_clk        (clk),
        .i_w_reset      (rst),
        .i_w_start      (start),
        .i_w_src        (src),
        .i_w_dst        (dst),
        .i_w_src_ext    (src_ext),
        .i_w_ext_data   (ext_data),
        .i_w_bus_in     (bus_in),
        .o_w_oe         (oe),
        .o_w_we         (we),
        .o_w_bus        (bus),
        .o_w_busy       (busy),
        .o_w_done       (done),
        .o_w_err        (err),
        .o_w_xfer_count (xfer_count)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 8; i++)
            if (we[i]) regs[i] <= bus;
    end

    always_comb begin
        bus_in = '0;
        for (int i = 0; i < 8; i++)
            if (oe[i]) bus_in = bus_in | regs[i];
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_oe", {24'd0, oe}, 32'h0);
        check("rst_we", {24'd0, we}, 32'h0);
        check("rst_bus", {16'd0, bus}, 32'h0);
        check("rst_flags", {29'd0, busy, done, err}, 32'h0);
        check("rst_count", {24'd0, xfer_count}, 32'h0);
        tick();
        rst = 1'b0;

        // External preload R2 = 0x1234
        start = 1'b1; src_ext = 1'b1; dst = 3'd2; ext_data = 16'h1234;
        tick();
        start = 1'b0;
        check("ext_we", {24'd0, we}, 32'h04);
        check("ext_oe", {24'd0, oe}, 32'h00);
        check("ext_bus", {16'd0, bus}, 32'h1234);
        check("ext_busy", {31'd0, busy}, 32'h1);
        tick();
        check("ext_done", {31'd0, done}, 32'h1);
        check("ext_count", {24'd0, xfer_count}, 32'd1);
        check("ext_we_off", {24'd0, we}, 32'h0);
        check("ext_r2", {16'd0, regs[2]}, 32'h1234);
        tick();
        check("ext_done_off", {31'd0, done}, 32'h0);
        $display("[TB] xfer ext->R2 data=1234 count=%0d", xfer_count);

        // Register transfer R2 -> R5
        start = 1'b1; src_ext = 1'b0; src = 3'd2; dst = 3'd5;
        tick();
        start = 1'b0;
        check("r25_oe", {24'd0, oe}, 32'h04);
        check("r25_we_rd", {24'd0, we}, 32'h00);
        check("r25_bus_rd", {16'd0, bus}, 32'h0);
        tick();
        check("r25_we", {24'd0, we}, 32'h20);
        check("r25_oe_wr", {24'd0, oe}, 32'h00);
        check("r25_bus", {16'd0, bus}, 32'h1234);
        tick();
        check("r25_done", {31'd0, done}, 32'h1);
        check("r25_count", {24'd0, xfer_count}, 32'd2);
        check("r25_r5", {16'd0, regs[5]}, 32'h1234);
        tick();
        $display("[TB] xfer R2->R5 data=%h count=%0d", regs[5], xfer_count);

        // src == dst without an external source is rejected
        start = 1'b1; src = 3'd3; dst = 3'd3;
        tick();
        start = 1'b0;
        check("err_pulse", {31'd0, err}, 32'h1);
        check("err_strobes", {16'd0, oe, we}, 32'h0);
        check("err_busy", {31'd0, busy}, 32'h0);
        tick();
        check("err_off", {31'd0, err}, 32'h0);
        check("err_strobes2", {16'd0, oe, we}, 32'h0);
        check("err_count", {24'd0, xfer_count}, 32'd2);
        $display("[TB] xfer R3->R3 rejected count=%0d", xfer_count);

        // Preload R1 = 0xA5A5
        start = 1'b1; src_ext = 1'b1; dst = 3'd1; ext_data = 16'hA5A5;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre1_count", {24'd0, xfer_count}, 32'd3);
        $display("[TB] xfer ext->R1 data=A5A5 count=%0d", xfer_count);

        // R1 -> R4 with start held high and the indices changed mid-transfer
        start = 1'b1; src_ext = 1'b0; src = 3'd1; dst = 3'd4;
        tick();
        check("hold_oe", {24'd0, oe}, 32'h02);
        src = 3'd3; dst = 3'd6;
        tick();
        check("hold_we", {24'd0, we}, 32'h10);
        check("hold_bus", {16'd0, bus}, 32'hA5A5);
        tick();
        check("hold_done", {31'd0, done}, 32'h1);
        check("hold_count", {24'd0, xfer_count}, 32'd4);
        start = 1'b0;
        tick();
        check("hold_idle", {30'd0, busy, done}, 32'h0);
        check("hold_count2", {24'd0, xfer_count}, 32'd4);
        check("hold_r4", {16'd0, regs[4]}, 32'hA5A5);
        check("hold_r6", {16'd0, regs[6]}, 32'h0);
        $display("[TB] xfer R1->R4 data=%h count=%0d", regs[4], xfer_count);

        // Reset during READ of R2 -> R6
        start = 1'b1; src = 3'd2; dst = 3'd6;
        tick();
        start = 1'b0;
        check("abort_oe_rd", {24'd0, oe}, 32'h04);
        rst = 1'b1;
        #1;
        check("abort_strobes", {16'd0, oe, we}, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'h0);
        check("abort_count", {24'd0, xfer_count}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("abort_r6", {16'd0, regs[6]}, 32'h0);
        check("abort_idle", {29'd0, busy, done, err}, 32'h0);
        $display("[TB] xfer R2->R6 aborted by reset count=%0d", xfer_count);

        // 256 external transfers: the counter wraps back to zero
        done_base = done_cnt;
        for (int i = 0; i < 256; i++) begin
            start = 1'b1; src_ext = 1'b1; dst = i[2:0]; ext_data = i[15:0];
            tick();
            start = 1'b0;
            tick();
            if (i == 254) check("wrap_255", {24'd0, xfer_count}, 32'd255);
            tick();
            $display("[TB] xfer ext->R%0d data=%h count=%0d", i % 8, regs[i % 8], xfer_count);
        end
        check("wrap_count", {24'd0, xfer_count}, 32'd0);
        check("wrap_done_pulses", done_cnt - done_base, 32'd256);
        check("wrap_r7", {16'd0, regs[7]}, 32'h00FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
